// File: rtl/sram_arbiter.sv
// sram_arbiter
// Arbitrates three requesters onto the shared 18-bit x 16-bit off-chip SRAM
// and sequences each access as SETUP / STROBE / HOLD with explicit strobes.
// Priority is D > I > V, except that V jumps to the front once it has waited
// V_MAX_WAIT cycles so frame fetch never misses its deadline.
//
// Ports
//   clk, rst                     system clock, async active-low reset
//   d_req/d_we/d_addr/d_wdata    CPU data port request (read/write)
//   d_ack/d_rdata                one-cycle ack, read data held until next read
//   i_req/i_addr, i_ack/i_rdata  instruction fetch port (read-only)
//   v_req/v_addr, v_ack/v_rdata  frame fetch port (read-only)
//   sram_addr, sram_data         SRAM address and bidirectional data bus
//   mem_en_n/mem_oe_n/mem_we_n   SRAM chip, output and write enables (active-low)
//
// state  | meaning
// IDLE   | no access, chip disabled, bus released
// SETUP  | address (and write data) presented, chip enabled
// STROBE | OE or WE low for STROBE_CYCLES cycles
// HOLD   | strobes high, address/data held, winner acked, re-arbitrate
module sram_arbiter #(
    parameter int STROBE_CYCLES = 1,
    parameter int V_MAX_WAIT    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [17:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    input  logic        i_req,
    input  logic [17:0] i_addr,
    output logic        i_ack,
    output logic [15:0] i_rdata,
    input  logic        v_req,
    input  logic [17:0] v_addr,
    output logic        v_ack,
    output logic [15:0] v_rdata,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        mem_en_n,
    output logic        mem_oe_n,
    output logic        mem_we_n
);

    localparam int CntW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    typedef enum logic [1:0] {PORT_D, PORT_I, PORT_V} port_t;

    state_t          state, nextState;
    port_t           curPort, winPort;
    logic            winValid;
    logic            dElig, iElig, vElig;
    logic [17:0]     addrReg;
    logic            weReg;
    logic [15:0]     wdataReg;
    logic [CntW-1:0] strobeCnt;
    logic [7:0]      vWait;
    logic            vActive;
    logic            busDrive;

    assign vActive = (state != IDLE) && (curPort == PORT_V);

    always_comb begin
        dElig     = d_req;
        iElig     = i_req;
        vElig     = v_req;
        winValid  = 1'b0;
        winPort   = PORT_D;
        nextState = state;
        // The port being acked in HOLD may still show req this cycle.
        if (state == HOLD) begin
            case (curPort)
                PORT_D:  dElig = 1'b0;
                PORT_I:  iElig = 1'b0;
                default: vElig = 1'b0;
            endcase
        end
        if (state == IDLE || state == HOLD) begin
            if (vElig && (int'(vWait) >= V_MAX_WAIT)) begin
                winValid = 1'b1;
                winPort  = PORT_V;
            end else if (dElig) begin
                winValid = 1'b1;
                winPort  = PORT_D;
            end else if (iElig) begin
                winValid = 1'b1;
                winPort  = PORT_I;
            end else if (vElig) begin
                winValid = 1'b1;
                winPort  = PORT_V;
            end
        end
        case (state)
            IDLE:    if (winValid) nextState = SETUP;
            SETUP:   nextState = STROBE;
            STROBE:  if (strobeCnt == '0) nextState = HOLD;
            default: nextState = winValid ? SETUP : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            curPort   <= PORT_D;
            addrReg   <= '0;
            weReg     <= 1'b0;
            wdataReg  <= '0;
            strobeCnt <= '0;
            vWait     <= '0;
            d_ack     <= 1'b0;
            i_ack     <= 1'b0;
            v_ack     <= 1'b0;
            d_rdata   <= '0;
            i_rdata   <= '0;
            v_rdata   <= '0;
        end else begin
            state <= nextState;
            d_ack <= (nextState == HOLD) && (curPort == PORT_D);
            i_ack <= (nextState == HOLD) && (curPort == PORT_I);
            v_ack <= (nextState == HOLD) && (curPort == PORT_V);

            if (winValid) begin
                curPort  <= winPort;
                weReg    <= (winPort == PORT_D) && d_we;
                wdataReg <= d_wdata;
                case (winPort)
                    PORT_D:  addrReg <= d_addr;
                    PORT_I:  addrReg <= i_addr;
                    default: addrReg <= v_addr;
                endcase
            end

            if (state == SETUP)
                strobeCnt <= CntW'(STROBE_CYCLES - 1);
            else if (state == STROBE && strobeCnt != '0)
                strobeCnt <= strobeCnt - 1'b1;

            if (state == STROBE && strobeCnt == '0 && !weReg) begin
                case (curPort)
                    PORT_D:  d_rdata <= sram_data;
                    PORT_I:  i_rdata <= sram_data;
                    default: v_rdata <= sram_data;
                endcase
            end

            if (!v_req || (winValid && winPort == PORT_V))
                vWait <= '0;
            else if (!vActive && vWait != 8'hFF)
                vWait <= vWait + 8'd1;
        end
    end

    // Outputs decode straight from state so an async reset releases the
    // strobes and the bus without waiting for a clock edge.
    assign busDrive  = weReg && (state != IDLE);
    assign sram_data = busDrive ? wdataReg : 16'hzzzz;
    assign sram_addr = addrReg;
    assign mem_en_n  = (state == IDLE);
    assign mem_oe_n  = !((state == STROBE) && !weReg);
    assign mem_we_n  = !((state == STROBE) && weReg);

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Three-port arbiter and access sequencer for the shared 18-bit × 16-bit off-chip SRAM on the motherboard. It sits between the memory wrapper's SRAM pins and three requesters: the CPU MEM-stage data port (D, read/write), the IF instruction-fetch port (I, read-only) and the graphic card frame fetch (V, read-only). It serialises their requests into single SRAM accesses with the SRAM control strobes timed explicitly. Fixed priority applies, plus a starvation guard that protects VGA timing.

## Interface
- STROBE_CYCLES, 1: cycles the OE/WE strobe is held low (≥1).
- V_MAX_WAIT, 8: cycles V may wait before it gets top priority (≥1, ≤255).

- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- d_req  in  1  data-port request; held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  18  data-port word address
- d_wdata  in  16  write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  16  read data; valid with d_ack, held until the next D read completes
- i_req / i_addr[17:0] / i_ack / i_rdata[15:0]: same as D, read-only
- v_req / v_addr[17:0] / v_ack / v_rdata[15:0]: same as D, read-only
- sram_addr  out  18  SRAM address
- sram_data  inout  16  SRAM data; driven only during a write access, otherwise Z
- mem_en_n, mem_oe_n, mem_we_n  out  1  SRAM chip enable, output enable, write enable (active-low)

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- Arbitration is evaluated in IDLE and in HOLD.
  - Winner is V if v_wait ≥ V_MAX_WAIT.
  - Otherwise the order is D > I > V.
  - In HOLD, the port currently being acked is excluded from arbitration.
- On a winner, latch the port id, address, we and wdata, then enter SETUP. If there is no winner, go to or stay in IDLE.
- SETUP (1 cycle):
  - sram_addr = latched address, mem_en_n = 0.
  - For a write, sram_data is driven with wdata.
- STROBE (STROBE_CYCLES cycles, internal down-counter):
  - Read: mem_oe_n = 0.
  - Write: mem_we_n = 0 and data driven.
  - On the last STROBE edge, read data is registered into the winner's rdata.
- HOLD (1 cycle):
  - Strobes high, address held, write data still driven, mem_en_n = 0.
  - The winner's ack = 1.
  - Next state is SETUP if there is a new winner, else IDLE.
- In IDLE: mem_en_n = 1, sram_data = Z, sram_addr holds its last value.
- v_wait (8-bit, saturating) increments each cycle v_req = 1 and V is not the latched winner. It clears when V is latched as winner or when v_req = 0.
- A requester deasserting req before its ack is a protocol violation. The access still completes and acks.
- Write-then-read turnaround: the data bus is released at the end of HOLD. The next read's OE falls no earlier than the following SETUP→STROBE edge, so there is no contention.

## Timing
- Reset values:
  - State IDLE.
  - mem_en_n = mem_oe_n = mem_we_n = 1, sram_data = Z.
  - sram_addr = 0, all acks = 0, all rdata = 0, v_wait = 0, strobe counter = 0.
- Reset mid-access: strobes deassert and the bus goes to Z asynchronously. The access is aborted with no ack, and operation restarts from IDLE after rst rises.
- Latency:
  - req seen at edge N in IDLE → ack high in cycle N+2+STROBE_CYCLES (3 cycles at the default).
  - Back-to-back accesses cost 2+STROBE_CYCLES cycles each, with no IDLE bubble.
- Acks are registered, exactly one cycle wide, and at most one ack is high per cycle.
- Simultaneous requests plus a starving V: V wins even if D is pending.
- Worst-case V grant delay is V_MAX_WAIT + (2+STROBE_CYCLES) cycles after v_req, because the access in flight always completes.
- Saturation: v_wait stops at 255.

## Test plan
- Reset: hold rst = 0 for 3 cycles → strobes all 1, sram_data Z, acks 0, rdata 0. After release, the block stays in IDLE with mem_en_n = 1.
- D write: addr 0x00123, data 0xBEEF.
  - mem_we_n low for exactly 1 cycle, with sram_addr = 0x00123 and data 0xBEEF.
  - d_ack arrives on the 3rd cycle after the request.
  - Bus returns to Z the cycle after the ack.
- D read of 0x00123 (SRAM model returns 0xBEEF) → mem_oe_n low for 1 cycle, d_rdata = 0xBEEF with d_ack, held afterwards.
- D, I and V raised together and held until acked → acks in order D, I, V at cycles 3, 6, 9. No IDLE between accesses, and no port is acked twice.
- Starvation: D and I re-request immediately after every ack, and v_req is held → v_ack no later than cycle V_MAX_WAIT + 3 + 3 = 14 (default parameters). After the ack, v_wait is 0.
- Reset pulse during the STROBE of a write → mem_we_n rises within the reset assertion with no clock edge required. No d_ack, and IDLE follows release.
